// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM states, access-engine phases
// and the controller register map.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SETUP, S_WR_STROBE, S_WR_GAP, S_OP_PULSE,
    S_OP_WAIT, S_RD_SETUP, S_RD_STROBE, S_RD_CAPTURE, S_RESP
  } state_t;

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_GAP} phase_t;

  localparam logic [1:0] REG_RES = 2'b00;
  localparam logic [1:0] REG_A   = 2'b01;
  localparam logic [1:0] REG_B   = 2'b10;
  localparam logic [1:0] REG_OP  = 2'b11;

  // Write index 0/1/2 maps to operand A, operand B, opcode.
  function automatic logic [1:0] wr_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return REG_A;
      2'd1:    return REG_B;
      default: return REG_OP;
    endcase
  endfunction

endpackage

// File: rtl/mc_reg_access.sv
// Three-phase controller access engine (setup / strobe / gap) shared by register
// writes and the result read; all bus outputs are registered.
module mc_reg_access
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              done,
  output logic              cs,
  output logic              wr_enb,
  output logic              rd_enb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] GAP_LAST_RD = CW'(RD_LAT - 1);

  phase_t          phase;
  logic            rd_mode;
  logic [CW-1:0]   gap_cnt;

  // A read stretches the gap into RD_LAT capture cycles; a write gap is one cycle.
  assign done = (phase == PH_GAP) && (!rd_mode || gap_cnt == GAP_LAST_RD);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_IDLE;
      rd_mode  <= 1'b0;
      gap_cnt  <= '0;
      cs       <= 1'b0;
      wr_enb   <= 1'b0;
      rd_enb   <= 1'b0;
      bus_addr <= '0;
      wr_data  <= '0;
    end else if (start) begin
      phase    <= PH_SETUP;
      rd_mode  <= is_read;
      gap_cnt  <= '0;
      cs       <= 1'b1;
      wr_enb   <= 1'b0;
      rd_enb   <= 1'b0;
      bus_addr <= addr;
      wr_data  <= is_read ? '0 : data;
    end else begin
      case (phase)
        PH_SETUP: begin
          phase  <= PH_STROBE;
          wr_enb <= !rd_mode;
          rd_enb <= rd_mode;
        end
        PH_STROBE: begin
          phase  <= PH_GAP;
          cs     <= 1'b0;
          wr_enb <= 1'b0;
          rd_enb <= 1'b0;
        end
        PH_GAP: begin
          if (done) begin
            phase    <= PH_IDLE;
            bus_addr <= '0;
            wr_data  <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Host-side sequencer: one ALU command in, controller write/op/read sequence out,
// result back. Define ALU_SEQ_SKIP_EN to skip writes that match shadowed values.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 2,
  parameter int OP_WAIT = 2,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [DATA_W-1:0] cmd_op,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              mc_cs,
  output logic              mc_wr_enb,
  output logic              mc_rd_enb,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_wr_data,
  output logic              mc_op_start,
  input  logic [DATA_W-1:0] mc_rd_data
);

  localparam int WCW = (OP_WAIT > 1) ? $clog2(OP_WAIT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(OP_WAIT - 1);

  state_t                  state;
  logic [2:0][DATA_W-1:0]  hold, vals;
  logic [2:0]              need;
  logic [1:0]              widx, from, nxt;
  logic [WCW-1:0]          wait_cnt;
  logic                    eng_start, eng_read, eng_done;
  logic [ADDR_W-1:0]       eng_addr;
  logic [DATA_W-1:0]       eng_data;

  // In IDLE the first access is chosen from the live inputs so a skip costs no cycle.
  always_comb begin
    vals = (state == S_IDLE) ? {cmd_op, cmd_b, cmd_a} : hold;
    from = (state == S_IDLE) ? 2'd0 : widx + 2'd1;
    nxt  = 2'd3;
    for (int i = 2; i >= 0; i--)
      if (i >= int'(from) && need[i]) nxt = 2'(i);
    case (nxt)
      2'd0:    eng_data = vals[0];
      2'd1:    eng_data = vals[1];
      default: eng_data = vals[2];
    endcase
  end

`ifdef ALU_SEQ_SKIP_EN
  logic [2:0][DATA_W-1:0] shadow;
  logic [2:0]             shadow_vld;

  always_comb begin
    need = '0;
    for (int i = 0; i < 3; i++)
      need[i] = !(shadow_vld[i] && shadow[i] == vals[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      shadow_vld <= '0;
    end else if (state == S_WR_STROBE) begin
      shadow[widx]     <= hold[widx];
      shadow_vld[widx] <= 1'b1;
    end
  end
`else
  assign need = 3'b111;
`endif

  assign eng_read  = (state == S_OP_WAIT);
  assign eng_addr  = eng_read ? ADDR_W'(REG_RES) : ADDR_W'(wr_addr(nxt));
  assign eng_start = (cmd_ready && cmd_valid && nxt != 2'd3)
                  || (state == S_WR_GAP && eng_done && nxt != 2'd3)
                  || (state == S_OP_WAIT && wait_cnt == WAIT_LAST);

  mc_reg_access #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_access (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start),
    .is_read  (eng_read),
    .addr     (eng_addr),
    .data     (eng_data),
    .done     (eng_done),
    .cs       (mc_cs),
    .wr_enb   (mc_wr_enb),
    .rd_enb   (mc_rd_enb),
    .bus_addr (mc_addr),
    .wr_data  (mc_wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= '0;
      mc_op_start <= 1'b0;
      widx        <= 2'd0;
      hold        <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          hold      <= vals;
          cmd_ready <= 1'b0;
          widx      <= nxt;
          if (nxt == 2'd3) begin
            state       <= S_OP_PULSE;
            mc_op_start <= 1'b1;
          end else begin
            state <= S_WR_SETUP;
          end
        end
        S_WR_SETUP:  state <= S_WR_STROBE;
        S_WR_STROBE: state <= S_WR_GAP;
        S_WR_GAP: if (eng_done) begin
          if (nxt == 2'd3) begin
            state       <= S_OP_PULSE;
            mc_op_start <= 1'b1;
          end else begin
            state <= S_WR_SETUP;
            widx  <= nxt;
          end
        end
        S_OP_PULSE: begin
          mc_op_start <= 1'b0;
          wait_cnt    <= '0;
          state       <= S_OP_WAIT;
        end
        S_OP_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_RD_SETUP;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        S_RD_SETUP:  state <= S_RD_STROBE;
        S_RD_STROBE: state <= S_RD_CAPTURE;
        S_RD_CAPTURE: if (eng_done) begin
          res_data  <= mc_rd_data;
          res_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: if (res_ready) begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: bus sequence, latency, handshakes, reset abort.
// Expectations follow ALU_SEQ_SKIP_EN when it is defined for the build.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, res_valid, res_ready;
  logic [3:0] cmd_a, cmd_b, cmd_op, res_data, mc_wr_data, mc_rd_data;
  logic       mc_cs, mc_wr_enb, mc_rd_enb, mc_op_start;
  logic [1:0] mc_addr;

  int errors = 0, checks = 0;
  logic [1:0] wa[8];
  logic [3:0] wd[8];
  int nwr, op_cnt, op_cyc, rd_cyc, rv_cyc;
  logic [1:0] rd_addr;

  int proto_viol = 0, proto_n = 0;
  logic       prev_cs = 1'b0;
  logic [1:0] prev_addr = 2'b0;
  logic [3:0] prev_data = 4'b0;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .mc_cs(mc_cs), .mc_wr_enb(mc_wr_enb), .mc_rd_enb(mc_rd_enb), .mc_addr(mc_addr),
    .mc_wr_data(mc_wr_data), .mc_op_start(mc_op_start), .mc_rd_data(mc_rd_data)
  );

  // Bus rules watched over the whole run; judged in test_protocol.
  always @(negedge clk) begin
    proto_n++;
    if (mc_wr_enb && mc_rd_enb) proto_viol++;
    if (mc_op_start && mc_cs) proto_viol++;
    if (prev_cs && mc_cs && (mc_addr !== prev_addr || mc_wr_data !== prev_data)) proto_viol++;
    prev_cs = mc_cs; prev_addr = mc_addr; prev_data = mc_wr_data;
  end

  // Offers one command, logs the bus until res_valid (or 40 cycles). Read data is
  // only correct in the capture window so a mistimed capture shows up in res_data.
  task automatic issue(input logic [3:0] a, b, op, rdv,
                       input bit busy_alt, input logic [3:0] aa, ab, aop);
    int rd_cnt;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    nwr = 0; op_cnt = 0; op_cyc = -1; rd_cyc = -1; rv_cyc = -1; rd_cnt = -1;
    mc_rd_data = ~rdv;
    for (int c = 1; c <= 40 && rv_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (busy_alt) begin cmd_a = aa; cmd_b = ab; cmd_op = aop; end
        else cmd_valid = 1'b0;
      end
      if (mc_wr_enb && nwr < 8) begin wa[nwr] = mc_addr; wd[nwr] = mc_wr_data; nwr++; end
      if (mc_op_start) begin op_cnt++; op_cyc = c; end
      if (rd_cnt >= 0) rd_cnt++;
      if (mc_rd_enb) begin rd_cyc = c; rd_addr = mc_addr; mc_rd_data = rdv; rd_cnt = 0; end
      if (rd_cnt >= 2) mc_rd_data = ~rdv;
      if (res_valid) rv_cyc = c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, res_valid, res_data} !== 6'b10_0000) begin
      errors++; $display("FAIL reset_handshake: got %b want 100000", {cmd_ready, res_valid, res_data});
    end
    checks++;
    if ({mc_cs, mc_wr_enb, mc_rd_enb, mc_op_start, mc_addr, mc_wr_data} !== 10'b0) begin
      errors++; $display("FAIL reset_bus: got %b want 0", {mc_cs, mc_wr_enb, mc_rd_enb, mc_op_start, mc_addr, mc_wr_data});
    end
    rst = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, res_valid, mc_cs} !== 3'b100) begin
      errors++; $display("FAIL idle_res_ready: got %b want 100", {cmd_ready, res_valid, mc_cs});
    end
  endtask

  task automatic test_basic();
    logic [5:0] exp_w[3];
    exp_w = '{6'b01_1010, 6'b10_1010, 6'b11_0011};
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", cmd_ready); end
    issue(4'b1010, 4'b1010, 4'b0011, 4'b0100, 1'b0, 4'h0, 4'h0, 4'h0);
    checks++;
    if (nwr !== 3) begin errors++; $display("FAIL basic_nwr: got %0d want 3", nwr); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wa[i], wd[i]} !== exp_w[i]) begin
        errors++; $display("FAIL basic_write%0d: got %b want %b", i, {wa[i], wd[i]}, exp_w[i]);
      end
    end
    checks++;
    if (op_cnt !== 1 || op_cyc !== 10) begin
      errors++; $display("FAIL basic_op_start: got cnt=%0d cyc=%0d want 1/10", op_cnt, op_cyc);
    end
    checks++;
    if (rd_cyc !== 14 || rd_addr !== 2'b00) begin
      errors++; $display("FAIL basic_read: got cyc=%0d addr=%b want 14/00", rd_cyc, rd_addr);
    end
    checks++;
    if (rv_cyc !== 16) begin errors++; $display("FAIL basic_latency: got %0d want 16", rv_cyc); end
    checks++;
    if ({res_data, cmd_ready} !== 5'b0100_0) begin
      errors++; $display("FAIL basic_result: got %b want 01000", {res_data, cmd_ready});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL basic_release: got %b want 01", {res_valid, cmd_ready});
    end
  endtask

  task automatic test_skip_repeat();
    logic [5:0] exp_w[3];
    int exp_n, exp_op, exp_rd, exp_rv;
`ifdef ALU_SEQ_SKIP_EN
    exp_w = '{6'b11_0101, 6'b0, 6'b0};
    exp_n = 1; exp_op = 4; exp_rd = 8; exp_rv = 10;
`else
    exp_w = '{6'b01_1010, 6'b10_1010, 6'b11_0101};
    exp_n = 3; exp_op = 10; exp_rd = 14; exp_rv = 16;
`endif
    issue(4'b1010, 4'b1010, 4'b0101, 4'b0110, 1'b0, 4'h0, 4'h0, 4'h0);
    checks++;
    if (nwr !== exp_n) begin errors++; $display("FAIL skip_nwr: got %0d want %0d", nwr, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if ({wa[i], wd[i]} !== exp_w[i]) begin
        errors++; $display("FAIL skip_write%0d: got %b want %b", i, {wa[i], wd[i]}, exp_w[i]);
      end
    end
    checks++;
    if (op_cyc !== exp_op || rd_cyc !== exp_rd || rv_cyc !== exp_rv) begin
      errors++; $display("FAIL skip_timing: got op=%0d rd=%0d rv=%0d want %0d/%0d/%0d",
                         op_cyc, rd_cyc, rv_cyc, exp_op, exp_rd, exp_rv);
    end
    checks++;
    if (res_data !== 4'b0110) begin errors++; $display("FAIL skip_result: got %b want 0110", res_data); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_hold();
    issue(4'b0001, 4'b0010, 4'b0011, 4'b1001, 1'b0, 4'h0, 4'h0, 4'h0);
    checks++;
    if (rv_cyc !== 16) begin errors++; $display("FAIL hold_latency: got %0d want 16", rv_cyc); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, res_data, cmd_ready} !== 6'b1_1001_0) begin
        errors++; $display("FAIL hold_cycle%0d: got %b want 110010", c, {res_valid, res_data, cmd_ready});
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_release: got %b want 01", {res_valid, cmd_ready});
    end
  endtask

  task automatic test_busy_ignore();
    logic [5:0] exp1[3], exp2[3];
    exp1 = '{6'b01_0100, 6'b10_0101, 6'b11_0110};
    exp2 = '{6'b01_1111, 6'b10_1110, 6'b11_1101};
    issue(4'b0100, 4'b0101, 4'b0110, 4'b0111, 1'b1, 4'b1111, 4'b1110, 4'b1101);
    checks++;
    if (nwr !== 3 || rv_cyc !== 16 || res_data !== 4'b0111) begin
      errors++; $display("FAIL busy_first: got nwr=%0d rv=%0d data=%b want 3/16/0111", nwr, rv_cyc, res_data);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wa[i], wd[i]} !== exp1[i]) begin
        errors++; $display("FAIL busy_write%0d: got %b want %b", i, {wa[i], wd[i]}, exp1[i]);
      end
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({res_valid, cmd_ready} !== 2'b10) begin
        errors++; $display("FAIL busy_resp_ready: got %b want 10", {res_valid, cmd_ready});
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; cmd_valid = 1'b0;
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL busy_release: got %b want 01", {res_valid, cmd_ready});
    end
    issue(4'b1111, 4'b1110, 4'b1101, 4'b1000, 1'b0, 4'h0, 4'h0, 4'h0);
    checks++;
    if (nwr !== 3 || rv_cyc !== 16 || res_data !== 4'b1000) begin
      errors++; $display("FAIL busy_second: got nwr=%0d rv=%0d data=%b want 3/16/1000", nwr, rv_cyc, res_data);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wa[i], wd[i]} !== exp2[i]) begin
        errors++; $display("FAIL busy2_write%0d: got %b want %b", i, {wa[i], wd[i]}, exp2[i]);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int hit, bad;
    logic [5:0] exp_w[3];
    exp_w = '{6'b01_0011, 6'b10_0011, 6'b11_0100};
    @(negedge clk);
    cmd_a = 4'b0011; cmd_b = 4'b1100; cmd_op = 4'b0001; cmd_valid = 1'b1;
    hit = -1;
    for (int c = 1; c <= 20 && hit < 0; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      if (mc_wr_enb && mc_addr == 2'b10) hit = c;
    end
    checks++;
    if (hit !== 5) begin errors++; $display("FAIL rstmid_b_strobe: got cyc=%0d want 5", hit); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({mc_cs, mc_wr_enb, mc_rd_enb, mc_op_start, mc_addr, mc_wr_data, cmd_ready, res_valid} !== 12'b0000_00_0000_10) begin
      errors++; $display("FAIL rstmid_state: got %b want 000000000010",
                         {mc_cs, mc_wr_enb, mc_rd_enb, mc_op_start, mc_addr, mc_wr_data, cmd_ready, res_valid});
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mc_cs || mc_wr_enb || mc_rd_enb || mc_op_start || !cmd_ready || res_valid) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
    issue(4'b0011, 4'b0011, 4'b0100, 4'b0101, 1'b0, 4'h0, 4'h0, 4'h0);
    checks++;
    if (nwr !== 3 || rv_cyc !== 16 || res_data !== 4'b0101) begin
      errors++; $display("FAIL rstmid_recover: got nwr=%0d rv=%0d data=%b want 3/16/0101", nwr, rv_cyc, res_data);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wa[i], wd[i]} !== exp_w[i]) begin
        errors++; $display("FAIL rstmid_write%0d: got %b want %b", i, {wa[i], wd[i]}, exp_w[i]);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_protocol();
    @(negedge clk);
    checks++;
    if (proto_viol !== 0 || proto_n < 100) begin
      errors++; $display("FAIL protocol: got %0d violations in %0d cycles want 0", proto_viol, proto_n);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; mc_rd_data = '0;
    test_reset();
    test_basic();
    test_skip_repeat();
    test_hold();
    test_busy_ignore();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
